// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - single-clock FIFO on an inferred dual-port RAM with normal or show-ahead read
module sync_fifo_ram #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int SHOW_AHEAD   = 0,
    parameter int AFULL_LEVEL  = 2**ADDR_WIDTH - 4,
    parameter int AEMPTY_LEVEL = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  head_valid;
    logic                  head_next;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  fetch;
    logic [ADDR_WIDTH:0]   ram_words;
    logic [ADDR_WIDTH:0]   count_next;

    // In show-ahead mode the registered RAM read port doubles as the head register,
    // so a fetch happens whenever the head is free and a previously written word exists.
    always_comb begin
        wr_acc    = wr_req && !full;
        rd_acc    = rd_req && !empty;
        ram_words = count - {{ADDR_WIDTH{1'b0}}, head_valid};
        if (SHOW_AHEAD != 0) begin
            fetch     = (!head_valid || rd_acc) && (ram_words != '0);
            head_next = fetch ? 1'b1 : (rd_acc ? 1'b0 : head_valid);
        end else begin
            fetch     = rd_acc;
            head_next = 1'b0;
        end
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + CNT_ONE;
        end else if (!wr_acc && rd_acc) begin
            count_next = count - CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && !clear && wr_acc) begin
            ram[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            head_valid   <= 1'b0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            head_valid   <= 1'b0;
            rd_valid     <= 1'b0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (fetch) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                rd_data <= ram[rd_ptr];
            end
            count        <= count_next;
            head_valid   <= head_next;
            full         <= (count_next == DEPTH_C);
            almost_full  <= (count_next >= AFULL_C);
            almost_empty <= (count_next <= AEMPTY_C);
            if (SHOW_AHEAD != 0) begin
                empty    <= !head_next;
                rd_valid <= head_next;
            end else begin
                empty    <= (count_next == '0);
                rd_valid <= rd_acc;
            end
            if (wr_req && full) begin
                overflow <= 1'b1;
            end
            if (rd_req && empty) begin
                underflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sync_fifo_ram.sv
// tb/tb_sync_fifo_ram.sv - self-checking bench for sync_fifo_ram in normal and show-ahead modes
module tb_sync_fifo_ram;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        wr_req = 1'b0;
    logic [31:0] wr_data = '0;
    logic        rd_req = 1'b0;

    logic [31:0] n_rd_data, s_rd_data;
    logic        n_rd_valid, s_rd_valid, n_empty, s_empty, n_full, s_full;
    logic        n_aempty, s_aempty, n_afull, s_afull, n_ovf, s_ovf, n_unf, s_unf;
    logic [8:0]  n_count;
    logic [4:0]  s_count;

    sync_fifo_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .SHOW_AHEAD(0), .AFULL_LEVEL(252), .AEMPTY_LEVEL(4)) dut_n (
        .clock(clock), .reset_n(reset_n), .clear(clear), .wr_req(wr_req), .wr_data(wr_data),
        .rd_req(rd_req), .rd_data(n_rd_data), .rd_valid(n_rd_valid), .empty(n_empty), .full(n_full),
        .almost_empty(n_aempty), .almost_full(n_afull), .count(n_count), .overflow(n_ovf), .underflow(n_unf));

    sync_fifo_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .SHOW_AHEAD(1), .AFULL_LEVEL(12), .AEMPTY_LEVEL(3)) dut_s (
        .clock(clock), .reset_n(reset_n), .clear(clear), .wr_req(wr_req), .wr_data(wr_data),
        .rd_req(rd_req), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .empty(s_empty), .full(s_full),
        .almost_empty(s_aempty), .almost_full(s_afull), .count(s_count), .overflow(s_ovf), .underflow(s_unf));

    always #5 clock = ~clock;

    bit sa = 1'b0;
    int dep = 256, afl = 252, ael = 4;
    int errors = 0, checks = 0;

    logic [31:0] mq[$];
    bit          mhv, mov, mun, mvalid;
    logic [31:0] mdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit e_empty;
        e_empty = sa ? !mhv : (mq.size() == 0);
        chk({tag, ".count"}, sa ? 32'(s_count) : 32'(n_count), 32'(mq.size()));
        chk({tag, ".full"}, 32'(sa ? s_full : n_full), 32'(mq.size() == dep));
        chk({tag, ".empty"}, 32'(sa ? s_empty : n_empty), 32'(e_empty));
        chk({tag, ".afull"}, 32'(sa ? s_afull : n_afull), 32'(mq.size() >= afl));
        chk({tag, ".aempty"}, 32'(sa ? s_aempty : n_aempty), 32'(mq.size() <= ael));
        chk({tag, ".rd_valid"}, 32'(sa ? s_rd_valid : n_rd_valid), 32'(sa ? mhv : mvalid));
        if (!sa || mhv) chk({tag, ".rd_data"}, sa ? s_rd_data : n_rd_data, mdata);
        chk({tag, ".overflow"}, 32'(sa ? s_ovf : n_ovf), 32'(mov));
        chk({tag, ".underflow"}, 32'(sa ? s_unf : n_unf), 32'(mun));
    endtask

    task automatic model_reset();
        mq.delete();
        mhv = 0; mov = 0; mun = 0; mvalid = 0; mdata = '0;
    endtask

    // Reference: the head shows the oldest word written at an earlier edge.
    task automatic model_edge();
        int  sz;
        bit  full_b, empty_b, wacc, racc;
        if (clear) begin
            mq.delete();
            mhv = 0; mov = 0; mun = 0; mvalid = 0;
            return;
        end
        sz      = mq.size();
        full_b  = (sz == dep);
        empty_b = sa ? !mhv : (sz == 0);
        if (wr_req && full_b) mov = 1;
        if (rd_req && empty_b) mun = 1;
        wacc = wr_req && !full_b;
        racc = rd_req && !empty_b;
        if (sa) begin
            if (racc) void'(mq.pop_front());
            mhv = (mq.size() > 0);
            if (mhv) mdata = mq[0];
        end else begin
            if (racc) mdata = mq.pop_front();
            mvalid = racc;
        end
        if (wacc) mq.push_back(wr_data);
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all(tag);
    endtask

    task automatic drive(input bit w, input logic [31:0] d, input bit r, input bit c, input string tag);
        wr_req = w; wr_data = d; rd_req = r; clear = c;
        tick(tag);
    endtask

    task automatic do_reset();
        wr_req = 0; rd_req = 0; clear = 0;
        reset_n = 0;
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1;
        check_all("reset");
    endtask

    initial begin
        do_reset();
        for (int i = 1; i <= 256; i++) drive(1, 32'(i), 0, 0, "fill");
        drive(1, 32'hDEADBEEF, 0, 0, "wr_full");
        drive(0, '0, 0, 0, "ovf_sticky");
        for (int i = 0; i < 256; i++) drive(0, '0, 1, 0, "drain");
        drive(0, '0, 0, 0, "idle");
        for (int i = 0; i < 5; i++) drive(1, $urandom, 0, 0, "pre5");
        for (int i = 0; i < 1000; i++) drive(1, $urandom, 1, 0, "simul");
        drive(1, 32'h12345678, 0, 1, "clear_wr");
        drive(0, '0, 1, 0, "rd_empty");
        for (int i = 0; i < 300; i++)
            drive($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 49) == 0, "rand_n");

        drive(0, '0, 0, 1, "clr2");
        for (int i = 0; i < 37; i++) drive(1, $urandom, 0, 0, "burst");
        wr_req = 1; wr_data = $urandom;
        #2 reset_n = 0;
        #1 model_reset();
        check_all("rst_mid");
        @(negedge clock);
        reset_n = 1;
        check_all("rst_rel");
        drive(1, 32'hCAFE0001, 0, 0, "post_wr");
        drive(0, '0, 1, 0, "post_rd");
        drive(0, '0, 0, 0, "post_idle");

        sa = 1; dep = 16; afl = 12; ael = 3;
        do_reset();
        drive(1, 32'hA5A5A5A5, 0, 0, "sa_wr");
        drive(0, '0, 0, 0, "sa_head");
        drive(0, '0, 1, 0, "sa_pop1");
        drive(0, '0, 0, 0, "sa_idle");
        for (int i = 0; i < 10; i++) drive(1, 32'h100 + 32'(i), 0, 0, "sa_fill10");
        drive(0, '0, 0, 0, "sa_settle");
        for (int i = 0; i < 10; i++) drive(0, '0, 1, 0, "sa_pop10");
        drive(0, '0, 1, 0, "sa_unf");
        for (int i = 0; i < 500; i++)
            drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 59) == 0, "rand_sa");
        for (int i = 0; i < 300; i++)
            drive($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) == 1, 0, "rand_sa2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sync_fifo_ram.md
# sync_fifo_ram

Single-clock, parametrised FIFO built on an inferred simple dual-port RAM with a registered read port, for buffering streams such as image-upgrade payload words between blocks that share one clock domain. It adds what a bare RAM lacks: pointer management, full/empty and programmable threshold flags, an occupancy count, sticky error flags, a synchronous flush, and a selectable normal or show-ahead read mode.

## Interface
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 8, RAM address width; DEPTH = 2**ADDR_WIDTH words, all usable.
- SHOW_AHEAD, 0, 0 = normal read (data follows the request); 1 = head word is presented before the request.
- AFULL_LEVEL, 2**ADDR_WIDTH-4, almost_full threshold; legal range 1..DEPTH.
- AEMPTY_LEVEL, 4, almost_empty threshold; legal range 0..DEPTH-1.

Ports:
- clock  in  1  single clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush; takes priority over wr_req and rd_req in the same cycle.
- wr_req  in  1  write request.
- wr_data  in  DATA_WIDTH  write data, sampled with wr_req.
- rd_req  in  1  read request (normal mode) or pop (show-ahead mode).
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  normal mode: 1-cycle pulse marking rd_data valid. Show-ahead mode: equals !empty.
- empty, full  out  1  status flags.
- almost_empty, almost_full  out  1  threshold flags.
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- overflow, underflow  out  1  sticky error flags.

## Operation
- Accept rules: the write is accepted when wr_req && !full, and the read is accepted when rd_req && !empty. Both use the registered flag values from the start of the cycle.
  - When full and a read and write arrive together, the read is accepted and the write is rejected.
  - When empty and a read and write arrive together, the write is accepted and the read is rejected.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH bits wide.
  - Each increments on an accepted access and wraps from DEPTH-1 to 0.
  - full/empty are derived from count, not from pointer equality.
- count:
  - +1 on a write only; -1 on a read only; unchanged on both or neither.
  - In show-ahead mode, count includes the word held in the head register.
- full = (count == DEPTH). almost_full = (count >= AFULL_LEVEL). almost_empty = (count <= AEMPTY_LEVEL).
- Normal mode:
  - An accepted read registers ram[rd_ptr].
  - rd_data holds that value until the next accepted read.
  - empty = (count == 0).
- Show-ahead mode:
  - A head register with a valid bit is fed from the RAM read port; empty = !head_valid.
  - The head refills whenever it is invalid, or is being popped, and RAM holds unread words. Back-to-back pops therefore sustain 1 word per cycle.
  - empty may be 1 while count is 1 during the refill cycle.
- Errors:
  - overflow sets on wr_req && full.
  - underflow sets on rd_req && empty.
  - Both stay set until clear or reset. Rejected accesses change no other state.
- clear:
  - Next edge: pointers and count go to 0, head_valid and rd_valid go to 0, overflow and underflow go to 0.
  - RAM contents and rd_data are unchanged.
- Reset (asynchronous, mid-operation allowed): same effect as clear, plus rd_data goes to 0. RAM contents are not reset.
- Output reset values:
  - rd_data = 0, rd_valid = 0, count = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = 0, underflow = 0.

## Timing
- All outputs are registered; none combinationally depend on wr_req or rd_req.
- A write accepted at edge N:
  - count, full and the threshold flags reflect it after edge N.
  - Normal mode: empty deasserts after edge N.
  - Show-ahead mode, writing into an empty FIFO: empty deasserts and rd_data is valid after edge N+1 (2-cycle write-to-head latency).
- Normal-mode read accepted at edge N: rd_data and rd_valid are valid after edge N for exactly one cycle (1-cycle latency).
- Show-ahead pop at edge N: the next word is on rd_data after edge N when RAM held one; otherwise empty asserts after edge N.
- Read-during-write at the same address cannot return stale data. This is guaranteed by the accept rules plus the head refill rule: a word is read only after the edge that wrote it.

## Test plan
- Reset, then write 0x00000001..0x00000100 with DEPTH=256 -> count=256, full=1 after the last edge, almost_full=1 from count 252.
- Write while full with 0xDEADBEEF -> rejected, overflow=1 and sticky. The following 256 reads return 0x1..0x100 in order, with rd_valid one cycle after each request.
- Simultaneous wr_req/rd_req for 1000 cycles at count=5 -> count stays 5, data order preserved, pointers wrap past 255 without error.
- SHOW_AHEAD=1: write 0xA5A5A5A5 into an empty FIFO -> empty=0 and rd_data=0xA5A5A5A5 two edges later. Ten back-to-back pops of 10 words yield all 10 words in consecutive cycles.
- rd_req while empty -> underflow=1, count stays 0. clear asserted together with wr_req -> count=0, flags cleared, write discarded.
- Assert reset_n low mid-burst (count=37) between clock edges -> outputs take their reset values immediately. After release, the FIFO is empty and the first new write reads back correctly.
